pfd_lockdet: RTL and testbench
==============================

Name: pfd_lockdet

Overview:
- Parametrised, clocked successor to the behavioural phase-frequency detector.
- Oversamples the reference and feedback clocks on a fast system clock and drives tri-state UP/DN to the charge pump.
- Guarantees a programmable minimum overlap pulse to suppress the dead zone.
- Also reports a signed phase error per comparison, counts cycle slips and asserts a lock flag with hysteresis.
- Sits between refclk/finalclk and cp_cosim in the PLL/CDR loop.

Parameters:
MIN_PW, 2, clk cycles UP and DN are held high together before reset (anti-dead-zone), >=1
ERR_W, 8, width of signed phase_err
LOCK_TOL, 1, max |phase_err| in clk cycles counted as an aligned comparison
LOCK_CNT, 16, consecutive aligned comparisons needed to assert lock
UNLOCK_CNT, 4, consecutive misaligned comparisons needed to drop lock
SLIP_W, 8, width of slip counter

Ports:
clk  input  1  oversampling system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  detector enable
ref_in  input  1  reference clock (asynchronous to clk)
fb_in  input  1  feedback/divided clock (asynchronous to clk)
up  output  1  charge-pump up request
dn  output  1  charge-pump down request
phase_err  output  ERR_W  signed error of last comparison, clk cycles (+ = ref leads)
err_valid  output  1  one-cycle strobe, phase_err updated
lock  output  1  loop locked
slip_cnt  output  SLIP_W  saturating cycle-slip count

Behaviour:
- Reset (rst_n low, async): up=0, dn=0, phase_err=0, err_valid=0, lock=0, slip_cnt=0. FSM=IDLE. Synchronisers, good/bad counters and error accumulator cleared.
- Input path: ref_in and fb_in each pass through a 2-flop synchroniser, then a rising-edge detect (ref_r, fb_r). An input rising edge meeting setup at clk edge k gives up/dn high after edge k+2, i.e. 3-cycle latency.
- FSM states: IDLE, UP_ONLY, DN_ONLY, RST. Outputs are registered and decoded from state: up=1 in UP_ONLY/RST, dn=1 in DN_ONLY/RST.
- IDLE:
  - ref_r&fb_r -> RST, err accumulator=0.
  - ref_r -> UP_ONLY, acc=1.
  - fb_r -> DN_ONLY, acc=-1.
- UP_ONLY:
  - acc increments each cycle, saturating at +(2^(ERR_W-1)-1).
  - fb_r -> RST.
  - ref_r without fb_r -> cycle slip: slip_cnt+1 (saturating at all-ones), lock cleared immediately, good count cleared, stay UP_ONLY.
  - ref_r&fb_r together -> RST; no slip is counted.
- DN_ONLY: mirror of UP_ONLY. acc decrements, saturating at -(2^(ERR_W-1)-1). A slip is a fb_r without ref_r.
- RST:
  - On entry, phase_err<=acc and err_valid=1 for exactly one cycle.
  - Stays for MIN_PW cycles, then -> IDLE.
  - Edges arriving during RST are not lost: a latched pending flag per input is applied in the first IDLE cycle, with the same rules as IDLE.
- Lock evaluation at each err_valid:
  - |phase_err|<=LOCK_TOL: good+1 (saturating), bad=0. lock<=1 when good reaches LOCK_CNT.
  - Otherwise: bad+1, good=0. lock<=0 when bad reaches UNLOCK_CNT.
  - lock changes only on the cycle after err_valid or on a slip.
- en low (synchronous):
  - Next cycle FSM=IDLE, up=dn=0, pending flags cleared, good/bad cleared, lock=0.
  - phase_err and slip_cnt hold.
  - Synchronisers keep running, so no false edge is detected on re-enable.
- Reset asserted mid-pulse drops up/dn asynchronously. No glitch from up/dn both high except in RST.

Test Plan:
- Reset mid-UP_ONLY (up=1) -> up/dn/lock/slip_cnt=0 immediately; first comparison after release behaves normally.
- ref_in and fb_in rise on the same clk edge, 20-cycle period -> up=dn=1 for exactly MIN_PW=2 cycles; phase_err=0; err_valid strobes once per period; lock=1 on 16th comparison.
- ref leads fb by 5 clk cycles -> up high 5 cycles, then both high 2 cycles; phase_err=+5; with lock previously 1, lock drops after 4th such comparison.
- ref at period 20, fb at period 24 -> slip detected when a second ref edge precedes fb edge; slip_cnt increments, lock=0 same cycle; slip_cnt saturates at 255 under sustained slip.
- fb leads ref by 200 cycles -> phase_err saturates at -127, dn held throughout, no wrap.
- en dropped for 10 cycles while locked -> up=dn=0, lock=0, slip_cnt held; after en=1 aligned edges re-lock after 16 comparisons.

Source files
------------

// File: rtl/pfd_lockdet.sv
// Clocked phase-frequency detector: oversamples ref/fb on clk, drives UP/DN with a
// guaranteed overlap pulse, reports signed phase error, slip count and a lock flag.
module pfd_lockdet #(
  parameter int MIN_PW     = 2,
  parameter int ERR_W      = 8,
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int SLIP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ref_in,
  input  logic              fb_in,
  output logic              up,
  output logic              dn,
  output logic [ERR_W-1:0]  phase_err,
  output logic              err_valid,
  output logic              lock,
  output logic [SLIP_W-1:0] slip_cnt
);

  localparam int PW_W   = $clog2(MIN_PW + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic [ERR_W-1:0]  ERR_MAX   = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [ERR_W-1:0]  ERR_MIN   = ~ERR_MAX + ERR_W'(1);
  localparam logic [ERR_W-1:0]  TOL       = ERR_W'(LOCK_TOL);
  localparam logic [PW_W-1:0]   PW_LAST   = PW_W'(MIN_PW - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(UNLOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {IDLE, UP_ONLY, DN_ONLY, RST} state_t;

  state_t             state, state_nx;
  logic [2:0]         ref_sync, fb_sync;
  logic               ref_r, fb_r, ref_e, fb_e;
  logic [ERR_W-1:0]   acc, acc_nx, err_nx, err_mag;
  logic [PW_W-1:0]    pw_cnt, pw_nx;
  logic               pend_ref, pend_fb, pend_ref_nx, pend_fb_nx;
  logic               load_err, slip, aligned;
  logic [GOOD_W-1:0]  good;
  logic [BAD_W-1:0]   bad;

  // Bits [1:0] are the metastability synchroniser; bit 2 only feeds edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sync <= '0;
      fb_sync  <= '0;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_in};
      fb_sync  <= {fb_sync[1:0], fb_in};
    end
  end

  assign ref_r = ref_sync[1] & ~ref_sync[2];
  assign fb_r  = fb_sync[1] & ~fb_sync[2];
  assign ref_e = ref_r | pend_ref;
  assign fb_e  = fb_r | pend_fb;

  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    pw_nx       = pw_cnt;
    pend_ref_nx = pend_ref;
    pend_fb_nx  = pend_fb;
    load_err    = 1'b0;
    err_nx      = acc;
    slip        = 1'b0;
    if (!en) begin
      state_nx    = IDLE;
      pend_ref_nx = 1'b0;
      pend_fb_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pend_ref_nx = 1'b0;
          pend_fb_nx  = 1'b0;
          if (ref_e && fb_e) begin
            state_nx = RST;
            acc_nx   = '0;
            err_nx   = '0;
            load_err = 1'b1;
            pw_nx    = '0;
          end else if (ref_e) begin
            state_nx = UP_ONLY;
            acc_nx   = ERR_W'(1);
          end else if (fb_e) begin
            state_nx = DN_ONLY;
            acc_nx   = '1;
          end
        end
        UP_ONLY: begin
          // A simultaneous ref edge is absorbed into this comparison, not a slip.
          if (fb_r) begin
            state_nx = RST;
            load_err = 1'b1;
            pw_nx    = '0;
          end else begin
            if (acc != ERR_MAX) acc_nx = acc + ERR_W'(1);
            slip = ref_r;
          end
        end
        DN_ONLY: begin
          if (ref_r) begin
            state_nx = RST;
            load_err = 1'b1;
            pw_nx    = '0;
          end else begin
            if (acc != ERR_MIN) acc_nx = acc - ERR_W'(1);
            slip = fb_r;
          end
        end
        RST: begin
          if (ref_r) pend_ref_nx = 1'b1;
          if (fb_r)  pend_fb_nx  = 1'b1;
          if (pw_cnt == PW_LAST) state_nx = IDLE;
          else                   pw_nx    = pw_cnt + PW_W'(1);
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      up        <= 1'b0;
      dn        <= 1'b0;
      acc       <= '0;
      pw_cnt    <= '0;
      pend_ref  <= 1'b0;
      pend_fb   <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      slip_cnt  <= '0;
    end else begin
      state     <= state_nx;
      up        <= (state_nx == UP_ONLY) || (state_nx == RST);
      dn        <= (state_nx == DN_ONLY) || (state_nx == RST);
      acc       <= acc_nx;
      pw_cnt    <= pw_nx;
      pend_ref  <= pend_ref_nx;
      pend_fb   <= pend_fb_nx;
      err_valid <= load_err;
      if (load_err) phase_err <= err_nx;
      if (slip && (slip_cnt != '1)) slip_cnt <= slip_cnt + SLIP_W'(1);
    end
  end

  assign err_mag = phase_err[ERR_W-1] ? (~phase_err + ERR_W'(1)) : phase_err;
  assign aligned = (err_mag <= TOL);

  // Lock hysteresis: evaluated on the err_valid strobe, a slip clears lock at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good <= '0;
      bad  <= '0;
      lock <= 1'b0;
    end else if (!en) begin
      good <= '0;
      bad  <= '0;
      lock <= 1'b0;
    end else if (slip) begin
      good <= '0;
      lock <= 1'b0;
    end else if (err_valid) begin
      if (aligned) begin
        bad <= '0;
        if (good != GOOD_MAX) good <= good + GOOD_W'(1);
        if (good >= GOOD_LAST) lock <= 1'b1;
      end else begin
        good <= '0;
        if (bad != BAD_MAX) bad <= bad + BAD_W'(1);
        if (bad >= BAD_LAST) lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pfd_lockdet.sv
// Self-checking bench for pfd_lockdet: per-scenario tasks plus a phase_err scoreboard
// that is filled when stimulus is driven and drained on every err_valid strobe.
module tb_pfd_lockdet;

  logic       clk = 1'b0;
  logic       rst_n, en, ref_in, fb_in;
  logic       up, dn, err_valid, lock;
  logic [7:0] phase_err, slip_cnt;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int sb_exp;

  pfd_lockdet #(
    .MIN_PW(2), .ERR_W(8), .LOCK_TOL(1), .LOCK_CNT(16), .UNLOCK_CNT(4), .SLIP_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up), .dn(dn), .phase_err(phase_err), .err_valid(err_valid),
    .lock(lock), .slip_cnt(slip_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every comparison the DUT reports must match the next queued expectation.
  always @(negedge clk) begin
    if (err_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_err_valid phase_err=%0d expected=none", $signed(phase_err));
      end else begin
        sb_exp = exp_q.pop_front();
        if ($signed(phase_err) !== sb_exp) begin
          errors++;
          $display("[TB] FAIL sb_phase_err got=%0d exp=%0d", $signed(phase_err), sb_exp);
        end
      end
    end
  end

  // One window of cycles; inputs pulse high for pw cycles at each non-negative offset.
  task automatic do_period(input int period, input int r0, input int r1, input int f0,
                           input int f1, input int pw, output int n_up, output int n_dn,
                           output int n_both, output int n_ev);
    n_up = 0; n_dn = 0; n_both = 0; n_ev = 0;
    for (int c = 0; c < period; c++) begin
      @(negedge clk);
      if (up && !dn) n_up++;
      if (dn && !up) n_dn++;
      if (up && dn)  n_both++;
      if (err_valid) n_ev++;
      ref_in = (r0 >= 0 && c >= r0 && c < r0 + pw) || (r1 >= 0 && c >= r1 && c < r1 + pw);
      fb_in  = (f0 >= 0 && c >= f0 && c < f0 + pw) || (f1 >= 0 && c >= f1 && c < f1 + pw);
    end
  endtask

  task automatic test_reset();
    int nu, nd, nb, ne;
    rst_n = 1'b0; en = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (up !== 1'b0 || dn !== 1'b0 || err_valid !== 1'b0 || lock !== 1'b0 ||
        phase_err !== 8'd0 || slip_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got up=%b dn=%b ev=%b lock=%b err=%0d slip=%0d exp all zero",
               up, dn, err_valid, lock, phase_err, slip_cnt);
    end
    rst_n = 1'b1;
    do_period(4, -1, -1, -1, -1, 1, nu, nd, nb, ne);
  endtask

  task automatic test_aligned_lock();
    int nu, nd, nb, ne;
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(0);
      do_period(20, 0, -1, 0, -1, 3, nu, nd, nb, ne);
      checks++;
      if (nb !== 2 || nu !== 0 || nd !== 0) begin
        errors++;
        $display("[TB] FAIL aligned_pulse cmp=%0d got both=%0d up=%0d dn=%0d exp 2/0/0", i, nb, nu, nd);
      end
      checks++;
      if (ne !== 1) begin
        errors++;
        $display("[TB] FAIL aligned_strobe cmp=%0d got=%0d exp=1", i, ne);
      end
      checks++;
      if (lock !== (i >= 16)) begin
        errors++;
        $display("[TB] FAIL aligned_lock cmp=%0d got=%b exp=%b", i, lock, (i >= 16));
      end
    end
  endtask

  task automatic test_lead_unlock();
    int nu, nd, nb, ne;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(5);
      do_period(20, 0, -1, 5, -1, 3, nu, nd, nb, ne);
      checks++;
      if (nu !== 5 || nb !== 2 || nd !== 0) begin
        errors++;
        $display("[TB] FAIL lead_pulse cmp=%0d got up=%0d both=%0d dn=%0d exp 5/2/0", i, nu, nb, nd);
      end
      checks++;
      if (lock !== (i < 4)) begin
        errors++;
        $display("[TB] FAIL lead_lock cmp=%0d got=%b exp=%b", i, lock, (i < 4));
      end
    end
  endtask

  task automatic test_slip();
    int nu, nd, nb, ne;
    for (int p = 1; p <= 260; p++) begin
      do_period(8, 0, -1, -1, -1, 3, nu, nd, nb, ne);
      if (p == 1 || p == 2 || p == 100) begin
        checks++;
        if (slip_cnt !== 8'(p - 1) || lock !== (p == 1)) begin
          errors++;
          $display("[TB] FAIL slip_count p=%0d got slip=%0d lock=%b exp slip=%0d lock=%b",
                   p, slip_cnt, lock, p - 1, (p == 1));
        end
      end
    end
    checks++;
    if (slip_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL slip_saturate got=%0d exp=255", slip_cnt);
    end
    exp_q.push_back(127);
    do_period(20, -1, -1, 0, -1, 3, nu, nd, nb, ne);
    checks++;
    if (nb !== 2 || slip_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL slip_close got both=%0d slip=%0d exp 2/255", nb, slip_cnt);
    end
  endtask

  task automatic test_fb_lead_sat();
    int nu, nd, nb, ne;
    exp_q.push_back(-127);
    do_period(260, 200, -1, 0, -1, 3, nu, nd, nb, ne);
    checks++;
    if (nd !== 200 || nu !== 0 || nb !== 2) begin
      errors++;
      $display("[TB] FAIL fb_lead_pulse got dn=%0d up=%0d both=%0d exp 200/0/2", nd, nu, nb);
    end
  endtask

  task automatic test_en_drop();
    int nu, nd, nb, ne, waited, viol;
    @(negedge clk);
    ref_in = 1'b1;
    waited = 0;
    while (!up && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (up !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_up_timeout got up=%b exp=1", up);
    end
    en = 1'b0; ref_in = 1'b0;
    @(negedge clk);
    checks++;
    if (up !== 1'b0 || dn !== 1'b0 || lock !== 1'b0 || slip_cnt !== 8'd255 || phase_err !== 8'd0) begin
      errors++;
      $display("[TB] FAIL en_drop got up=%b dn=%b lock=%b slip=%0d err=%0d exp 0/0/0/255/0",
               up, dn, lock, slip_cnt, phase_err);
    end
    viol = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (up || dn || lock) viol++;
      ref_in = (i >= 1 && i < 4);
      fb_in  = (i >= 1 && i < 4);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("[TB] FAIL en_hold got active_cycles=%0d exp=0", viol);
    end
    en = 1'b1;
    do_period(4, -1, -1, -1, -1, 1, nu, nd, nb, ne);
    checks++;
    if (nu !== 0 || nd !== 0 || nb !== 0) begin
      errors++;
      $display("[TB] FAIL en_reenable got up=%0d dn=%0d both=%0d exp 0/0/0", nu, nd, nb);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int nu, nd, nb, ne, waited;
    @(negedge clk);
    ref_in = 1'b1;
    waited = 0;
    while (!up && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (up !== 1'b1 || lock !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre got up=%b lock=%b exp 1/1", up, lock);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (up !== 1'b0 || dn !== 1'b0 || lock !== 1'b0 || slip_cnt !== 8'd0 ||
        phase_err !== 8'd0 || err_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_async got up=%b dn=%b lock=%b slip=%0d err=%0d exp all zero",
               up, dn, lock, slip_cnt, phase_err);
    end
    ref_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_period(3, -1, -1, -1, -1, 1, nu, nd, nb, ne);
    exp_q.push_back(3);
    do_period(20, 0, -1, 3, -1, 3, nu, nd, nb, ne);
    checks++;
    if (nu !== 3 || nb !== 2 || nd !== 0 || ne !== 1) begin
      errors++;
      $display("[TB] FAIL rst_first_cmp got up=%0d both=%0d dn=%0d ev=%0d exp 3/2/0/1", nu, nb, nd, ne);
    end
  endtask

  task automatic test_back_to_back();
    int nu, nd, nb, ne;
    exp_q.push_back(0);
    exp_q.push_back(7);
    do_period(24, 0, 2, 0, 10, 1, nu, nd, nb, ne);
    checks++;
    if (nu !== 7 || nb !== 4 || nd !== 0 || ne !== 2) begin
      errors++;
      $display("[TB] FAIL pending_edge got up=%0d both=%0d dn=%0d ev=%0d exp 7/4/0/2", nu, nb, nd, ne);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_lead_unlock();
    test_aligned_lock();
    test_slip();
    test_fb_lead_sat();
    test_aligned_lock();
    test_en_drop();
    test_aligned_lock();
    test_reset_mid_pulse();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
